// File: rtl/rr_arbiter_8x3_pkg.sv
// Shared constants, FSM state type and round-robin search helper for rr_arbiter_8x3.
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Rotate so that index last_idx+1 lands on bit 0, then isolate the lowest set bit.
    // The result is one-hot in the rotated domain; add last_idx+1 to its index to un-rotate.
    function automatic logic [N_REQ-1:0] rr_rot_pick(input logic [N_REQ-1:0] req,
                                                     input logic [IDX_W-1:0] last_idx);
        logic [IDX_W-1:0] sh;
        logic [N_REQ-1:0] rot;
        sh  = last_idx + 3'd1;
        rot = 8'({req, req} >> sh);
        return rot & (~rot + 8'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter_8x3_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_8x3_if;
    import rr_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             timeout;

    modport master (output req, input gnt, gnt_idx, gnt_vld, timeout);
    modport slave  (input req, output gnt, gnt_idx, gnt_vld, timeout);

endinterface

// File: rtl/rr_arbiter_8x3_onehot_enc.sv
// Combinational 8-to-3 one-hot encoder (OR-of-bits form) with an any-bit-set flag.
module onehot_enc_8x3
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] onehot_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    assign idx_o[0] = onehot_i[1] | onehot_i[3] | onehot_i[5] | onehot_i[7];
    assign idx_o[1] = onehot_i[2] | onehot_i[3] | onehot_i[6] | onehot_i[7];
    assign idx_o[2] = onehot_i[4] | onehot_i[5] | onehot_i[6] | onehot_i[7];
    assign vld_o    = |onehot_i;

endmodule

// File: rtl/rr_arbiter_8x3.sv
// 8-requester round-robin arbiter with registered one-hot grant and encoded index.
// Optional grant-hold timeout with penalty mask: define RR_ARB_TIMEOUT_EN.
module rr_arbiter_8x3
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input logic            clk,
    input logic            rst_n,
    rr_arbiter_8x3_if.slave bus
);

    if (N_REQ != 8) begin : g_bad_nreq
        $error("rr_arbiter_8x3 supports exactly 8 requesters");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_arbiter_8x3 MAX_HOLD must be within 2..255");
    end

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             vld_q, vld_d;

    logic [N_REQ-1:0] req_elig;
    logic [N_REQ-1:0] pick_rot;
    logic [IDX_W-1:0] rot_idx;
    logic [IDX_W-1:0] win_idx;
    logic             any_elig;
    logic             revoke;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0]       hold_q, hold_d;
    logic [N_REQ-1:0] mask_q, mask_d;
    logic             timeout_q;

    assign req_elig = bus.req & ~mask_q;
    assign revoke   = (state_q == GRANT) && bus.req[idx_q] && (hold_q == HOLD_LAST);
    assign hold_d   = (state_q == GRANT) ? hold_q + 8'd1 : 8'd0;
    // A penalised requester stays masked until it is seen with req low.
    assign mask_d   = (mask_q & bus.req) | (revoke ? gnt_q : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= 8'd0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            mask_q    <= mask_d;
            timeout_q <= revoke;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign req_elig    = bus.req;
    assign revoke      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign pick_rot = rr_rot_pick(req_elig, last_q);

    onehot_enc_8x3 u_enc (
        .onehot_i (pick_rot),
        .idx_o    (rot_idx),
        .vld_o    (any_elig)
    );

    assign win_idx = rot_idx + last_q + 3'd1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d = GRANT;
                    gnt_d   = 8'd1 << win_idx;
                    idx_d   = win_idx;
                    vld_d   = 1'b1;
                    last_d  = win_idx;
                end
            end
            GRANT: begin
                if (!bus.req[idx_q] || revoke) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 3'd7;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_vld = vld_q;

endmodule

// File: tb/tb_rr_arbiter_8x3.sv
// Directed and random-invariant bench for rr_arbiter_8x3 (both RR_ARB_TIMEOUT_EN builds).
module tb_rr_arbiter_8x3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rr_arbiter_8x3_if bus ();

    rr_arbiter_8x3 #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    logic [7:0] req_v;
    int         wait_cnt [8];
    int         left [8];
    logic       prev_vld;
    int         w;

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bus.req = 8'h00;
        step(2);
        chk("rst_gnt", bus.gnt, 8'h00);
        chk("rst_idx", bus.gnt_idx, 3'd0);
        chk("rst_vld", bus.gnt_vld, 1'b0);
        chk("rst_timeout", bus.timeout, 1'b0);

        // single requester, 1-cycle latency each way
        rst_n   = 1'b1;
        bus.req = 8'h01;
        step(1);
        chk("r0_gnt", bus.gnt, 8'h01);
        chk("r0_idx", bus.gnt_idx, 3'd0);
        chk("r0_vld", bus.gnt_vld, 1'b1);
        bus.req = 8'h00;
        step(1);
        chk("r0_rel_gnt", bus.gnt, 8'h00);
        chk("r0_rel_vld", bus.gnt_vld, 1'b0);

        // all requesting, each holds two granted cycles: order 0..7,0
        do_reset();
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step(1);
            chk("rr_gnt_a", bus.gnt, 8'd1 << (k % 8));
            chk("rr_idx_a", bus.gnt_idx, k % 8);
            step(1);
            chk("rr_gnt_b", bus.gnt, 8'd1 << (k % 8));
            bus.req[k % 8] = 1'b0;
            step(1);
            chk("rr_idle", bus.gnt_vld, 1'b0);
            bus.req[k % 8] = 1'b1;
        end
        bus.req = 8'h00;
        step(2);

        // after serving 5, requesters 2 and 5: search starts at 6 and wraps to 2
        bus.req = 8'h20;
        step(1);
        chk("s5_idx", bus.gnt_idx, 3'd5);
        bus.req = 8'h00;
        step(1);
        bus.req = 8'h24;
        step(1);
        chk("wrap_idx", bus.gnt_idx, 3'd2);
        chk("wrap_gnt", bus.gnt, 8'h04);
        bus.req = 8'h20;
        step(1);
        chk("wrap_idle", bus.gnt, 8'h00);
        step(1);
        chk("wrap_then5", bus.gnt_idx, 3'd5);
        bus.req = 8'h00;
        step(2);

        // asynchronous reset mid-grant
        bus.req = 8'h08;
        step(1);
        chk("pre_rst_idx", bus.gnt_idx, 3'd3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", bus.gnt, 8'h00);
        chk("arst_idx", bus.gnt_idx, 3'd0);
        chk("arst_vld", bus.gnt_vld, 1'b0);
        chk("arst_timeout", bus.timeout, 1'b0);
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 8'h18;
        step(1);
        chk("arst_last7", bus.gnt_idx, 3'd3);
        bus.req = 8'h00;
        step(1);
        bus.req = 8'h80;
        step(1);
        chk("arst_r7", bus.gnt_idx, 3'd7);
        bus.req = 8'h00;
        step(2);

`ifdef RR_ARB_TIMEOUT_EN
        do_reset();
        bus.req = 8'h03;
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("to_hold_gnt", bus.gnt, 8'h01);
            chk("to_hold_tmo", bus.timeout, 1'b0);
        end
        step(1);
        chk("to_drop_gnt", bus.gnt, 8'h00);
        chk("to_pulse", bus.timeout, 1'b1);
        step(1);
        chk("to_next_gnt", bus.gnt, 8'h02);
        chk("to_pulse_end", bus.timeout, 1'b0);
        bus.req = 8'h01;
        step(1);
        chk("to_rel1", bus.gnt, 8'h00);
        step(1);
        chk("to_masked", bus.gnt, 8'h00);
        bus.req = 8'h00;
        step(1);
        chk("to_unmask_idle", bus.gnt, 8'h00);
        bus.req = 8'h01;
        step(1);
        chk("to_regrant0", bus.gnt, 8'h01);
        bus.req = 8'h00;
        step(2);
`else
        do_reset();
        bus.req = 8'h01;
        step(20);
        chk("nto_hold_gnt", bus.gnt, 8'h01);
        chk("nto_hold_vld", bus.gnt_vld, 1'b1);
        chk("nto_timeout", bus.timeout, 1'b0);
        bus.req = 8'h00;
        step(2);
`endif

        // random requesters that hold req until served for 1..3 cycles
        do_reset();
        req_v    = 8'h00;
        prev_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_cnt[i] = 0;
            left[i]     = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            chk("inv_onehot", bus.gnt & (bus.gnt - 8'd1), 8'h00);
            chk("inv_match", bus.gnt, bus.gnt_vld ? (8'd1 << bus.gnt_idx) : 8'h00);
            chk("inv_vld", bus.gnt_vld, bus.gnt != 8'h00);
            if (bus.gnt_vld && !prev_vld) begin
                w = int'(bus.gnt_idx);
                chk("fair_wait", wait_cnt[w] <= 7, 1'b1);
                wait_cnt[w] = 0;
                for (int i = 0; i < 8; i++)
                    if (i != w && req_v[i]) wait_cnt[i]++;
                left[w] = $urandom_range(0, 2);
            end
            if (bus.gnt_vld) begin
                if (left[bus.gnt_idx] == 0) req_v[bus.gnt_idx] = 1'b0;
                else left[bus.gnt_idx]--;
            end
            for (int i = 0; i < 8; i++)
                if (!req_v[i] && !(bus.gnt_vld && int'(bus.gnt_idx) == i)
                    && $urandom_range(0, 2) == 0)
                    req_v[i] = 1'b1;
            prev_vld = bus.gnt_vld;
            bus.req  = req_v;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
